// File: rtl/median_pkg.sv
// rtl/median_pkg.sv - shared types and defaults for the median filter datapath
package median_pkg;

  localparam int DATA_COUNT_DEF = 16;
  localparam int DATA_WIDTH_DEF = 12;

  typedef logic [DATA_WIDTH_DEF-1:0]                sample_t;
  typedef logic [DATA_COUNT_DEF*DATA_WIDTH_DEF-1:0] window_t;

  typedef enum logic [1:0] {
    EMPTY   = 2'd0,
    FILLING = 2'd1,
    STEADY  = 2'd2
  } window_state_t;

endpackage

// File: rtl/median_window.sv
// rtl/median_window.sv - sliding sample window feeding the median sort network
module median_window
  import median_pkg::*;
#(
  parameter int DATA_COUNT = DATA_COUNT_DEF,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int STRIDE     = 1
) (
  input  logic                               clock50MHz,
  input  logic                               reset,
  input  logic                               flush,
  input  logic                               sample_valid,
  output logic                               sample_ready,
  input  logic [DATA_WIDTH-1:0]              sample_data,
  output logic                               window_valid,
  input  logic                               window_ready,
  output logic [DATA_COUNT*DATA_WIDTH-1:0]   window_data,
  output logic [$clog2(DATA_COUNT+1)-1:0]    fill_count
);

  localparam int FW = $clog2(DATA_COUNT+1);
  localparam int SW = (DATA_COUNT > 1) ? $clog2(DATA_COUNT) : 1;
  localparam int WW = DATA_COUNT*DATA_WIDTH;

  localparam logic [FW-1:0] FILL_FULL   = FW'(DATA_COUNT);
  localparam logic [FW-1:0] FILL_LAST   = FW'(DATA_COUNT-1);
  localparam logic [SW-1:0] STRIDE_LAST = SW'(STRIDE-1);

  window_state_t   state_q, state_d;
  logic [WW-1:0]   shift_q, shift_d;
  logic [WW-1:0]   wdata_q, wdata_d;
  logic [FW-1:0]   fill_q, fill_d;
  logic [SW-1:0]   stride_q, stride_d;
  logic            wvalid_q, wvalid_d;
  logic            accept;
  logic            emit;

  // State register
  always_ff @(posedge clock50MHz or posedge reset) begin
    if (reset) begin
      state_q <= EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = EMPTY;
    end else if (accept) begin
      case (state_q)
        EMPTY:   state_d = FILLING;
        FILLING: state_d = (fill_q == FILL_LAST) ? STEADY : FILLING;
        default: state_d = state_q;
      endcase
    end
  end

  // Handshake and emission decode; a drain in the same cycle frees the stall
  always_comb begin
    sample_ready = !flush && !(wvalid_q && !window_ready);
    accept       = sample_valid && sample_ready;
    emit         = 1'b0;
    if (accept) begin
      case (state_q)
        FILLING: emit = (fill_q == FILL_LAST);
        STEADY:  emit = (stride_q == STRIDE_LAST);
        default: emit = 1'b0;
      endcase
    end
  end

  always_comb begin
    shift_d  = shift_q;
    wdata_d  = wdata_q;
    fill_d   = fill_q;
    stride_d = stride_q;
    wvalid_d = wvalid_q;
    if (flush) begin
      shift_d  = '0;
      fill_d   = '0;
      stride_d = '0;
      wvalid_d = 1'b0;
    end else begin
      if (wvalid_q && window_ready) begin
        wvalid_d = 1'b0;
      end
      if (accept) begin
        shift_d = {shift_q[WW-DATA_WIDTH-1:0], sample_data};
        if (fill_q != FILL_FULL) begin
          fill_d = fill_q + FW'(1);
        end
        if (state_q == STEADY) begin
          stride_d = emit ? '0 : stride_q + SW'(1);
        end else begin
          stride_d = '0;
        end
      end
      // The emitted window is the post-shift contents, including this sample
      if (emit) begin
        wdata_d  = shift_d;
        wvalid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clock50MHz or posedge reset) begin
    if (reset) begin
      shift_q  <= '0;
      wdata_q  <= '0;
      fill_q   <= '0;
      stride_q <= '0;
      wvalid_q <= 1'b0;
    end else begin
      shift_q  <= shift_d;
      wdata_q  <= wdata_d;
      fill_q   <= fill_d;
      stride_q <= stride_d;
      wvalid_q <= wvalid_d;
    end
  end

  assign window_valid = wvalid_q;
  assign window_data  = wdata_q;
  assign fill_count   = fill_q;

endmodule

// File: tb/tb_median_window.sv
// tb/tb_median_window.sv - vector table plus window scoreboard for median_window
module tb_median_window;
  import median_pkg::*;

  localparam int DC = 16;
  localparam int DW = 12;
  localparam int FW = $clog2(DC+1);

  typedef struct {
    int            sel;
    logic [DW-1:0] data;
    bit            valid;
    bit            wready;
    bit            fl;
    bit            exp_sready;
    int            exp_fill;
    bit            exp_wvalid;
    logic [DW-1:0] exp_s0;
    logic [DW-1:0] exp_sl;
  } vec_t;

  logic clk;
  logic rst, flush, s_valid, w_ready;
  logic [DW-1:0] s_data;
  int sel;

  logic sv1, sv4;
  logic sr1, sr4, wv1, wv4;
  window_t wd1, wd4;
  logic [FW-1:0] fc1, fc4;
  logic s_ready, w_valid;
  window_t w_data;
  logic [FW-1:0] f_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  vec_t tbl[$];
  logic [DW-1:0] m_sh [DC];
  int m_fill, m_since;
  bit m_pend;
  window_t sb_q[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign sv1 = s_valid && (sel == 0);
  assign sv4 = s_valid && (sel == 1);
  assign s_ready = (sel == 1) ? sr4 : sr1;
  assign w_valid = (sel == 1) ? wv4 : wv1;
  assign w_data  = (sel == 1) ? wd4 : wd1;
  assign f_cnt   = (sel == 1) ? fc4 : fc1;

  median_window #(.DATA_COUNT(DC), .DATA_WIDTH(DW), .STRIDE(1)) dut1 (
    .clock50MHz(clk), .reset(rst), .flush(flush),
    .sample_valid(sv1), .sample_ready(sr1), .sample_data(s_data),
    .window_valid(wv1), .window_ready(w_ready), .window_data(wd1),
    .fill_count(fc1)
  );

  median_window #(.DATA_COUNT(DC), .DATA_WIDTH(DW), .STRIDE(4)) dut4 (
    .clock50MHz(clk), .reset(rst), .flush(flush),
    .sample_valid(sv4), .sample_ready(sr4), .sample_data(s_data),
    .window_valid(wv4), .window_ready(w_ready), .window_data(wd4),
    .fill_count(fc4)
  );

  task automatic check(input string name, input logic [191:0] act, input logic [191:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input int s, input int d, input bit v, input bit wr, input bit f,
                              input bit esr, input int efill, input bit ewv, input int e0, input int el);
    vec_t r;
    r.sel = s; r.data = DW'(d); r.valid = v; r.wready = wr; r.fl = f;
    r.exp_sready = esr; r.exp_fill = efill; r.exp_wvalid = ewv;
    r.exp_s0 = DW'(e0); r.exp_sl = DW'(el);
    return r;
  endfunction

  function automatic window_t m_pack();
    window_t w;
    for (int i = 0; i < DC; i++) w[i*DW +: DW] = m_sh[i];
    return w;
  endfunction

  task automatic m_clear();
    for (int i = 0; i < DC; i++) m_sh[i] = '0;
    m_fill = 0; m_since = 0; m_pend = 0;
    sb_q.delete();
  endtask

  task automatic apply(input vec_t v);
    bit acc, emitted;
    int stride;
    window_t exp_w;
    sel = v.sel; s_data = v.data; s_valid = v.valid; w_ready = v.wready; flush = v.fl;
    #2;
    check("sample_ready", 192'(s_ready), 192'(v.exp_sready));
    stride = (v.sel == 1) ? 4 : 1;
    acc = v.valid && !v.fl && !(m_pend && !v.wready);
    if (v.fl) begin
      m_clear();
    end else begin
      if (m_pend && v.wready) begin
        exp_w = sb_q.pop_front();
        check("consumed_window", 192'(w_data), 192'(exp_w));
        m_pend = 0;
      end
      if (acc) begin
        for (int i = DC-1; i > 0; i--) m_sh[i] = m_sh[i-1];
        m_sh[0] = v.data;
        emitted = 0;
        if (m_fill < DC) begin
          m_fill++;
          if (m_fill == DC) begin
            emitted = 1;
            m_since = 0;
          end
        end else begin
          m_since++;
          if (m_since % stride == 0) emitted = 1;
        end
        if (emitted) begin
          sb_q.push_back(m_pack());
          m_pend = 1;
        end
      end
    end
    @(posedge clk); #1;
    check("fill_count", 192'(f_cnt), 192'(v.exp_fill));
    check("window_valid", 192'(w_valid), 192'(v.exp_wvalid));
    check("valid_vs_scoreboard", 192'(w_valid), 192'(sb_q.size() != 0));
    if (v.exp_wvalid) begin
      check("slot0", 192'(w_data[DW-1:0]), 192'(v.exp_s0));
      check("slot_last", 192'(w_data[DC*DW-1 -: DW]), 192'(v.exp_sl));
      if (sb_q.size() != 0) check("pending_window", 192'(w_data), 192'(sb_q[0]));
    end
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; s_valid = 1'b0; w_ready = 1'b0; s_data = '0; sel = 0;
    m_clear();

    // Scenarios 1-2: stride 1, fill and slide
    for (int k = 1; k <= 16; k++) tbl.push_back(mk(0, k, 1, 1, 0, 1, k, k == 16, 16, 1));
    for (int k = 17; k <= 20; k++) tbl.push_back(mk(0, k, 1, 1, 0, 1, 16, 1, k, k-15));
    tbl.push_back(mk(0, 0, 0, 1, 0, 1, 16, 0, 0, 0));
    // Scenario 3: backpressure then drain with a same-cycle accept
    tbl.push_back(mk(0, 21, 1, 0, 0, 1, 16, 1, 21, 6));
    for (int k = 0; k < 5; k++) tbl.push_back(mk(0, 22, 1, 0, 0, 0, 16, 1, 21, 6));
    tbl.push_back(mk(0, 22, 1, 1, 0, 1, 16, 1, 22, 7));
    tbl.push_back(mk(0, 0, 0, 1, 0, 1, 16, 0, 0, 0));
    // Scenario 5: flush mid-fill, flush blocks a valid sample, refill
    tbl.push_back(mk(0, 0, 0, 1, 1, 0, 0, 0, 0, 0));
    for (int k = 1; k <= 10; k++) tbl.push_back(mk(0, 100+k, 1, 1, 0, 1, k, 0, 0, 0));
    tbl.push_back(mk(0, 999, 1, 1, 1, 0, 0, 0, 0, 0));
    for (int k = 1; k <= 16; k++) tbl.push_back(mk(0, 200+k, 1, 1, 0, 1, k, k == 16, 216, 201));
    tbl.push_back(mk(0, 0, 0, 1, 1, 0, 0, 0, 0, 0));
    // Scenario 4: stride 4
    for (int k = 1; k <= 24; k++)
      tbl.push_back(mk(1, k, 1, 1, 0, 1, (k < 16) ? k : 16, (k == 16) || (k == 20) || (k == 24), k, k-15));
    tbl.push_back(mk(1, 0, 0, 1, 0, 1, 16, 0, 0, 0));
    tbl.push_back(mk(1, 0, 0, 1, 1, 0, 0, 0, 0, 0));

    repeat (2) @(posedge clk);
    #1;
    check("reset_fill", 192'(f_cnt), 192'(0));
    check("reset_wvalid", 192'(w_valid), 192'(0));
    check("reset_wdata", 192'(w_data), 192'(0));
    check("reset_sready", 192'(s_ready), 192'(1));
    rst = 1'b0;

    foreach (tbl[i]) apply(tbl[i]);

    // Scenario 6: asynchronous reset while a window is pending
    for (int k = 1; k <= 16; k++) apply(mk(0, 50+k, 1, 0, 0, 1, k, k == 16, 66, 51));
    s_valid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_wvalid", 192'(w_valid), 192'(0));
    check("async_rst_wdata", 192'(w_data), 192'(0));
    check("async_rst_fill", 192'(f_cnt), 192'(0));
    check("async_rst_sready", 192'(s_ready), 192'(1));
    @(posedge clk); #1;
    rst = 1'b0;
    m_clear();
    for (int i = 0; i < 21; i++) apply(tbl[i]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/median_window.md
Name: median_window

Overview:
Upstream stage of the median filter. Collects a stream of sensor samples into a sliding window of DATA_COUNT entries and presents each window as one packed vector to the sort network's input_data.
- Uses a valid/ready handshake on both sides.
- Stalls the sample source while a captured window has not yet been consumed.
- Supports a configurable stride between emitted windows.

Parameters:
DATA_COUNT, 16, window length; power of two, at least 2, matching the sort network.
DATA_WIDTH, 12, bits per sample.
STRIDE, 1, accepted samples between successive emitted windows once the window is full; 1 to DATA_COUNT.

Ports:
clock50MHz  in  1  system clock; all state updates on the rising edge.
reset  in  1  asynchronous, active-high reset.
flush  in  1  synchronous clear of the window contents and counters.
sample_valid  in  1  sample_data is valid this cycle.
sample_ready  out  1  block can accept a sample this cycle.
sample_data  in  DATA_WIDTH  incoming sample, unsigned.
window_valid  out  1  window_data holds a complete, unconsumed window.
window_ready  in  1  consumer takes window_data this cycle.
window_data  out  DATA_COUNT*DATA_WIDTH  packed window; slot i at bits [(i+1)*DATA_WIDTH-1 : i*DATA_WIDTH], slot 0 = newest sample.
fill_count  out  $clog2(DATA_COUNT+1)  number of valid samples in the window, saturating at DATA_COUNT.

Behaviour:
- Reset (asynchronous, active-high): shift register, window_data, fill_count, stride counter and window_valid all go to 0; state goes to EMPTY. sample_ready follows its combinational rule (1 after reset). Reset asserted mid-operation discards any pending window immediately.
- Accept: a sample is accepted when sample_valid && sample_ready. The shift register moves slot i to slot i+1, slot DATA_COUNT-1 is discarded, and sample_data enters slot 0.
- sample_ready = !flush && !(window_valid && !window_ready). This is a combinational stall: accepting in the same cycle the consumer drains is allowed.
- State machine:
  - EMPTY: fill_count = 0.
  - FILLING: 0 < fill_count < DATA_COUNT.
  - STEADY: fill_count = DATA_COUNT.
  - Transitions: EMPTY to FILLING on the first accept; FILLING to STEADY on the accept that brings fill_count to DATA_COUNT.
  - Any state returns to EMPTY on flush.
- Emission:
  - The accept that moves FILLING to STEADY is an emission and loads stride_cnt = 0.
  - In STEADY each accept increments stride_cnt. The accept on which stride_cnt reaches STRIDE-1 is an emission, and stride_cnt wraps to 0.
  - With STRIDE=1, every accept in STEADY is an emission.
- On an emission cycle, the post-shift window is loaded into the window_data register and window_valid=1 from the next cycle. Latency from emitting accept to window_valid is 1 cycle.
- window_data is stable while window_valid && !window_ready.
- Consumption: window_valid clears on window_valid && window_ready, unless an emission occurs in the same cycle. In that case window_valid stays 1 and window_data takes the new window.
- Accepts that are not emissions never alter window_data.
- flush (synchronous):
  - Zeroes the shift register, fill_count and stride_cnt, and clears window_valid.
  - Has priority over a same-cycle accept; sample_ready is 0 during flush, so no sample is taken.
  - Has priority over a same-cycle window_ready.
- fill_count saturates at DATA_COUNT and never wraps.

Decomposition:
- Package median_pkg holds:
  - DATA_COUNT_DEF = 16 and DATA_WIDTH_DEF = 12;
  - typedef sample_t (logic [DATA_WIDTH_DEF-1:0]);
  - typedef window_t (logic [DATA_COUNT_DEF*DATA_WIDTH_DEF-1:0]);
  - state enum window_state_t {EMPTY, FILLING, STEADY}.
  The sort network shares the same package.
- No sub-module. The shift register, counters and output register are a single always_ff plus the combinational ready/emission logic.

Test Plan:
1. STRIDE=1; feed samples 1..16 back-to-back with window_ready=1 -> window_valid rises exactly 1 cycle after the 16th accept; slot0=16, slot15=1; fill_count 0→16, then holds at 16.
2. Continue feeding 17 -> next window has slot0=17, slot15=2; window_valid stays 1 on consecutive cycles; no gaps with ready=1.
3. Backpressure: full window pending with window_ready=0 and sample_valid=1 for 5 cycles -> sample_ready=0 and window_data unchanged throughout. Raise window_ready -> the pending sample is accepted in the drain cycle and a new window appears the next cycle.
4. STRIDE=4; feed 1..24 with ready=1 -> windows emitted after samples 16 and 20 (slot0=16, then slot0=20) and 24; nothing after samples 17–19 or 21–23.
5. flush asserted with sample_valid=1 after 10 samples -> sample not taken; fill_count=0 next cycle; refill with 16 samples reaches the first window only after the 16th new sample, and all slots contain only post-flush data.
6. reset asserted mid-cycle while window_valid=1 -> window_valid, window_data and fill_count read 0 without waiting for a clock edge; after release, behaviour matches scenario 1.
